// File: rtl/ddr3_cpu_port_arbiter_pkg.sv
// Shared types and constants for the multi-port DDR3 CPU front end.
// The request payload is fixed by the controller's address/data widths.
package ddr3_cpu_port_arbiter_pkg;

   localparam int DQ_BITS       = 8;
   localparam int BURST_L       = 8;
   localparam int ADDR_MCTRL    = 28;
   localparam int ADDR_W        = ADDR_MCTRL;
   localparam int DATA_W        = 8 * DQ_BITS;
   localparam int DM_W          = BURST_L;
   localparam int NUM_PORTS_DEF = 4;

   localparam logic CMD_RD = 1'b0;
   localparam logic CMD_WR = 1'b1;

   typedef struct packed {
      logic              cmd;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wr_data;
      logic [DM_W-1:0]   dm;
   } mc_req_t;

   // Port index width, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int PORT_IDX_W = idx_w(NUM_PORTS_DEF);

endpackage

// File: rtl/ddr3_cpu_port_arbiter_if.sv
// Requester-side and controller-side signals of the port arbiter.
// slave = the arbiter, master = whatever drives it (agents plus controller model).
interface ddr3_cpu_port_arbiter_if #(
   parameter int NUM_PORTS = 4
) ();
   import ddr3_cpu_port_arbiter_pkg::*;

   logic [NUM_PORTS-1:0]        i_port_valid;
   logic [NUM_PORTS-1:0]        o_port_ready;
   logic [NUM_PORTS-1:0]        i_port_cmd;
   logic [NUM_PORTS*ADDR_W-1:0] i_port_addr;
   logic [NUM_PORTS*DATA_W-1:0] i_port_wr_data;
   logic [NUM_PORTS*DM_W-1:0]   i_port_dm;
   logic [DATA_W-1:0]           o_port_rd_data;
   logic [NUM_PORTS-1:0]        o_port_rd_valid;
   logic                        o_mc_valid;
   logic                        o_mc_cmd;
   logic [ADDR_W-1:0]           o_mc_addr;
   logic [DATA_W-1:0]           o_mc_wr_data;
   logic [DM_W-1:0]             o_mc_dm;
   logic                        i_mc_data_rdy;
   logic [DATA_W-1:0]           i_mc_rd_data;
   logic                        i_mc_rd_data_valid;
   logic                        o_err_sticky;

   modport slave (
      input  i_port_valid, i_port_cmd, i_port_addr, i_port_wr_data, i_port_dm,
      input  i_mc_data_rdy, i_mc_rd_data, i_mc_rd_data_valid,
      output o_port_ready, o_port_rd_data, o_port_rd_valid,
      output o_mc_valid, o_mc_cmd, o_mc_addr, o_mc_wr_data, o_mc_dm, o_err_sticky
   );

   modport master (
      output i_port_valid, i_port_cmd, i_port_addr, i_port_wr_data, i_port_dm,
      output i_mc_data_rdy, i_mc_rd_data, i_mc_rd_data_valid,
      input  o_port_ready, o_port_rd_data, o_port_rd_valid,
      input  o_mc_valid, o_mc_cmd, o_mc_addr, o_mc_wr_data, o_mc_dm, o_err_sticky
   );

endinterface

// File: rtl/ddr3_sync_fifo.sv
// Show-ahead synchronous FIFO: head is valid whenever empty is low.
// Push when full and pop when empty are ignored.
module ddr3_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count_reg == CNT_W'(DEPTH));
   assign empty   = (count_reg == '0);
   assign head    = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= push_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/ddr3_cpu_port_arbiter.sv
// Per-port request queues, round-robin grant into a registered command stage,
// and in-order read-data steering back to the issuing port.
module ddr3_cpu_port_arbiter
   import ddr3_cpu_port_arbiter_pkg::*;
#(
   parameter int NUM_PORTS      = 4,
   parameter int REQ_DEPTH      = 4,
   parameter int RD_OUTSTANDING = 8
) (
   input logic                    i_cpu_ck,
   input logic                    i_cpu_rst_n,
   ddr3_cpu_port_arbiter_if.slave bus
);
   localparam int IDX_W = idx_w(NUM_PORTS);
   localparam int REQ_W = $bits(mc_req_t);

   mc_req_t              head [NUM_PORTS];
   logic [NUM_PORTS-1:0] port_ready;
   logic [NUM_PORTS-1:0] req_full;
   logic [NUM_PORTS-1:0] req_empty;
   logic [NUM_PORTS-1:0] req_pop;
   logic [NUM_PORTS-1:0] eligible;
   logic                 ord_full;
   logic                 ord_empty;
   logic                 ord_push;
   logic [IDX_W-1:0]     ord_head;
   logic [IDX_W-1:0]     rr_ptr_reg;
   logic [IDX_W-1:0]     grant_idx;
   logic                 grant_found;
   logic                 load_en;
   mc_req_t              grant_req;
   logic                 mc_valid_reg;
   mc_req_t              mc_req_reg;
   logic [NUM_PORTS-1:0] rd_valid_reg;
   logic [DATA_W-1:0]    rd_data_reg;
   logic                 err_reg;

   generate
      for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         mc_req_t push_req;

         assign push_req = '{cmd:     bus.i_port_cmd[gi],
                             addr:    bus.i_port_addr[gi*ADDR_W +: ADDR_W],
                             wr_data: bus.i_port_wr_data[gi*DATA_W +: DATA_W],
                             dm:      bus.i_port_dm[gi*DM_W +: DM_W]};

         // Ready is withheld during reset so nothing is lost into a cleared queue.
         assign port_ready[gi] = !req_full[gi] && i_cpu_rst_n;
         assign eligible[gi]   = !req_empty[gi] && (head[gi].cmd == CMD_WR || !ord_full);
         assign req_pop[gi]    = load_en && (grant_idx == IDX_W'(gi));

         ddr3_sync_fifo #(.WIDTH(REQ_W), .DEPTH(REQ_DEPTH)) u_req_fifo (
            .clk       (i_cpu_ck),
            .rst_n     (i_cpu_rst_n),
            .push      (bus.i_port_valid[gi] && port_ready[gi]),
            .push_data (push_req),
            .pop       (req_pop[gi]),
            .head      (head[gi]),
            .full      (req_full[gi]),
            .empty     (req_empty[gi])
         );
      end
   endgenerate

   // First eligible port at or after the pointer, wrapping around.
   always_comb begin
      logic [IDX_W-1:0] cand_idx;
      grant_found = 1'b0;
      grant_idx   = '0;
      cand_idx    = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         cand_idx = IDX_W'((int'(rr_ptr_reg) + k) % NUM_PORTS);
         if (!grant_found && eligible[cand_idx]) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx;
         end
      end
   end

   assign grant_req = head[grant_idx];
   assign load_en   = (!mc_valid_reg || bus.i_mc_data_rdy) && grant_found;
   assign ord_push  = load_en && (grant_req.cmd == CMD_RD);

   ddr3_sync_fifo #(.WIDTH(IDX_W), .DEPTH(RD_OUTSTANDING)) u_ord_fifo (
      .clk       (i_cpu_ck),
      .rst_n     (i_cpu_rst_n),
      .push      (ord_push),
      .push_data (grant_idx),
      .pop       (bus.i_mc_rd_data_valid),
      .head      (ord_head),
      .full      (ord_full),
      .empty     (ord_empty)
   );

   always_ff @(posedge i_cpu_ck or negedge i_cpu_rst_n) begin
      if (!i_cpu_rst_n) begin
         rr_ptr_reg   <= '0;
         mc_valid_reg <= 1'b0;
         mc_req_reg   <= '0;
      end else if (load_en) begin
         rr_ptr_reg   <= (grant_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
         mc_valid_reg <= 1'b1;
         mc_req_reg   <= grant_req;
      end else if (bus.i_mc_data_rdy) begin
         mc_valid_reg <= 1'b0;
      end
   end

   // Returns with nothing outstanding are dropped and latched as an error.
   always_ff @(posedge i_cpu_ck or negedge i_cpu_rst_n) begin
      if (!i_cpu_rst_n) begin
         rd_valid_reg <= '0;
         rd_data_reg  <= '0;
         err_reg      <= 1'b0;
      end else begin
         rd_valid_reg <= '0;
         if (bus.i_mc_rd_data_valid) begin
            if (ord_empty) begin
               err_reg <= 1'b1;
            end else begin
               rd_valid_reg[ord_head] <= 1'b1;
               rd_data_reg            <= bus.i_mc_rd_data;
            end
         end
      end
   end

   assign bus.o_port_ready    = port_ready;
   assign bus.o_mc_valid      = mc_valid_reg;
   assign bus.o_mc_cmd        = mc_req_reg.cmd;
   assign bus.o_mc_addr       = mc_req_reg.addr;
   assign bus.o_mc_wr_data    = mc_req_reg.wr_data;
   assign bus.o_mc_dm         = mc_req_reg.dm;
   assign bus.o_port_rd_valid = rd_valid_reg;
   assign bus.o_port_rd_data  = rd_data_reg;
   assign bus.o_err_sticky    = err_reg;

endmodule

// File: tb/tb_ddr3_cpu_port_arbiter.sv
// Directed scenarios plus a random phase, all checked cycle by cycle against a
// queue-based model of per-port FIFOs, round-robin grant and in-order read return.
module tb_ddr3_cpu_port_arbiter;
   import ddr3_cpu_port_arbiter_pkg::*;

   localparam int NP  = 4;
   localparam int RQD = 4;
   localparam int RDO = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   ddr3_cpu_port_arbiter_if #(.NUM_PORTS(NP)) bus ();

   ddr3_cpu_port_arbiter #(.NUM_PORTS(NP), .REQ_DEPTH(RQD), .RD_OUTSTANDING(RDO)) dut (
      .i_cpu_ck    (clk),
      .i_cpu_rst_n (rst_n),
      .bus         (bus.slave)
   );

   // Reference model state
   mc_req_t           m_q [NP][$];
   int                m_ord[$];
   logic              m_stage_v;
   mc_req_t           m_stage;
   int                m_rr;
   logic              m_err;
   logic [NP-1:0]     m_rdv;
   logic [DATA_W-1:0] m_rdd;

   mc_req_t acc_log[$];
   int      total = 0;
   int      bad   = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic mc_req_t req_of(input int p);
      mc_req_t r;
      r.cmd     = bus.i_port_cmd[p];
      r.addr    = bus.i_port_addr[p*ADDR_W +: ADDR_W];
      r.wr_data = bus.i_port_wr_data[p*DATA_W +: DATA_W];
      r.dm      = bus.i_port_dm[p*DM_W +: DM_W];
      return r;
   endfunction

   function automatic mc_req_t dut_req();
      mc_req_t r;
      r.cmd     = bus.o_mc_cmd;
      r.addr    = bus.o_mc_addr;
      r.wr_data = bus.o_mc_wr_data;
      r.dm      = bus.o_mc_dm;
      return r;
   endfunction

   task automatic model_clear();
      for (int p = 0; p < NP; p++) m_q[p].delete();
      m_ord.delete();
      m_stage_v = 1'b0;
      m_stage   = '0;
      m_rr      = 0;
      m_err     = 1'b0;
      m_rdv     = '0;
      m_rdd     = '0;
   endtask

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_edge();
      bit pre_ready [NP];
      int pre_ord;
      int win;
      int p;
      int idx;
      pre_ord = m_ord.size();
      for (int i = 0; i < NP; i++) pre_ready[i] = (m_q[i].size() < RQD);
      win = -1;
      if (!m_stage_v || bus.i_mc_data_rdy) begin
         for (int k = 0; k < NP; k++) begin
            p = (m_rr + k) % NP;
            if (win < 0 && m_q[p].size() > 0 && (m_q[p][0].cmd == CMD_WR || pre_ord < RDO))
               win = p;
         end
      end
      if (m_stage_v && bus.i_mc_data_rdy) m_stage_v = 1'b0;
      if (win >= 0) begin
         m_stage   = m_q[win].pop_front();
         m_stage_v = 1'b1;
         m_rr      = (win + 1) % NP;
      end
      m_rdv = '0;
      if (bus.i_mc_rd_data_valid) begin
         if (pre_ord > 0) begin
            idx   = m_ord.pop_front();
            m_rdv = NP'(1) << idx;
            m_rdd = bus.i_mc_rd_data;
         end else begin
            m_err = 1'b1;
         end
      end
      if (win >= 0 && m_stage.cmd == CMD_RD) m_ord.push_back(win);
      for (int i = 0; i < NP; i++)
         if (bus.i_port_valid[i] && pre_ready[i]) m_q[i].push_back(req_of(i));
   endtask

   task automatic check_all();
      logic [NP-1:0] rdy_exp;
      for (int p = 0; p < NP; p++) rdy_exp[p] = (m_q[p].size() < RQD);
      check("ready", 128'(bus.o_port_ready), 128'(rdy_exp));
      check("mc_valid", 128'(bus.o_mc_valid), 128'(m_stage_v));
      if (m_stage_v) check("mc_req", 128'(dut_req()), 128'(m_stage));
      check("rd_valid", 128'(bus.o_port_rd_valid), 128'(m_rdv));
      if (|m_rdv) check("rd_data", 128'(bus.o_port_rd_data), 128'(m_rdd));
      check("err", 128'(bus.o_err_sticky), 128'(m_err));
   endtask

   task automatic step();
      mc_req_t r;
      if (bus.o_mc_valid && bus.i_mc_data_rdy) begin
         r = dut_req();
         acc_log.push_back(r);
         $display("mc accept t=%0t cmd=%0d addr=%h data=%h", $time, r.cmd, r.addr, r.wr_data);
      end
      model_edge();
      @(posedge clk);
      #1;
      if (|bus.o_port_rd_valid)
         $display("rd return t=%0t ports=%b data=%h", $time, bus.o_port_rd_valid, bus.o_port_rd_data);
      check_all();
   endtask

   task automatic idle();
      bus.i_port_valid       = '0;
      bus.i_port_cmd         = '0;
      bus.i_port_addr        = '0;
      bus.i_port_wr_data     = '0;
      bus.i_port_dm          = '0;
      bus.i_mc_data_rdy      = 1'b0;
      bus.i_mc_rd_data       = '0;
      bus.i_mc_rd_data_valid = 1'b0;
   endtask

   task automatic set_req(input int p, input logic cmd, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] data, input logic [DM_W-1:0] dm);
      bus.i_port_valid[p]                  = 1'b1;
      bus.i_port_cmd[p]                    = cmd;
      bus.i_port_addr[p*ADDR_W +: ADDR_W]  = addr;
      bus.i_port_wr_data[p*DATA_W +: DATA_W] = data;
      bus.i_port_dm[p*DM_W +: DM_W]        = dm;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      model_clear();
      #1;
      check("rst_ready", 128'(bus.o_port_ready), 128'(0));
      check("rst_mc_valid", 128'(bus.o_mc_valid), 128'(0));
      check("rst_mc_req", 128'(dut_req()), 128'(0));
      check("rst_rd_valid", 128'(bus.o_port_rd_valid), 128'(0));
      check("rst_rd_data", 128'(bus.o_port_rd_data), 128'(0));
      check("rst_err", 128'(bus.o_err_sticky), 128'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("rel_ready", 128'(bus.o_port_ready), 128'({NP{1'b1}}));
   endtask

   task automatic drain(input int n);
      bus.i_port_valid  = '0;
      bus.i_mc_data_rdy = 1'b1;
      repeat (n) begin
         bus.i_mc_rd_data_valid = (m_ord.size() > 0);
         bus.i_mc_rd_data       = {$urandom(), $urandom()};
         step();
      end
      bus.i_mc_rd_data_valid = 1'b0;
   endtask

   initial begin
      #20_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int seen[$];
      int first;
      int enq_cnt;
      int n_rd;
      int n_wr;
      logic [ADDR_W-1:0] exp_addr[$];
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d [3];

      idle();
      #2;
      do_reset();

      // Single write from port 2: visible two edges after presentation.
      bus.i_mc_data_rdy = 1'b1;
      set_req(2, CMD_WR, ADDR_W'(28'h100), 64'hA5A5_A5A5_A5A5_A5A5, 8'h00);
      step();
      bus.i_port_valid = '0;
      check("s1_early", 128'(bus.o_mc_valid), 128'(0));
      step();
      check("s1_valid", 128'(bus.o_mc_valid), 128'(1));
      check("s1_cmd", 128'(bus.o_mc_cmd), 128'(CMD_WR));
      check("s1_addr", 128'(bus.o_mc_addr), 128'(28'h100));
      check("s1_data", 128'(bus.o_mc_wr_data), 128'(64'hA5A5_A5A5_A5A5_A5A5));
      step();
      check("s1_one_cycle", 128'(bus.o_mc_valid), 128'(0));
      check("s1_no_rd", 128'(bus.o_port_rd_valid), 128'(0));

      // Fairness: three writes per port, expect 0,1,2,3 x3 with no bubble.
      do_reset();
      bus.i_mc_data_rdy = 1'b1;
      for (int c = 0; c < 3; c++) begin
         for (int p = 0; p < NP; p++)
            set_req(p, CMD_WR, ADDR_W'(p*16 + c), {$urandom(), $urandom()}, DM_W'($urandom()));
         step();
         seen.push_back(bus.o_mc_valid ? int'(bus.o_mc_addr[7:4]) : -1);
      end
      bus.i_port_valid = '0;
      repeat (15) begin
         step();
         seen.push_back(bus.o_mc_valid ? int'(bus.o_mc_addr[7:4]) : -1);
      end
      first = -1;
      foreach (seen[i]) if (first < 0 && seen[i] >= 0) first = i;
      check("s2_window", 128'(first >= 0 && first + 12 < seen.size()), 128'(1));
      if (first >= 0 && first + 12 < seen.size()) begin
         for (int k = 0; k < 12; k++) check("s2_grant", 128'(seen[first+k]), 128'(k % NP));
         check("s2_end", 128'(seen[first+12]), 128'(-1));
      end

      // Backpressure: port 0 streams while the controller stalls.
      do_reset();
      acc_log.delete();
      enq_cnt = 0;
      for (int c = 0; c < 10; c++) begin
         a = ADDR_W'($urandom());
         set_req(0, CMD_WR, a, {$urandom(), $urandom()}, DM_W'($urandom()));
         if (bus.o_port_ready[0]) enq_cnt++;
         if (m_q[0].size() < RQD) exp_addr.push_back(a);
         step();
      end
      check("s3_enq_count", 128'(enq_cnt), 128'(RQD + 1));
      check("s3_hold_valid", 128'(bus.o_mc_valid), 128'(1));
      if (exp_addr.size() > 0) check("s3_hold_addr", 128'(bus.o_mc_addr), 128'(exp_addr[0]));
      idle();
      bus.i_mc_data_rdy = 1'b1;
      repeat (8) step();
      check("s3_drain_count", 128'(acc_log.size()), 128'(exp_addr.size()));
      foreach (exp_addr[i])
         if (i < acc_log.size()) check("s3_order", 128'(acc_log[i].addr), 128'(exp_addr[i]));

      // Read steering: ports 3, 1, 0 read in that order.
      do_reset();
      bus.i_mc_data_rdy = 1'b1;
      set_req(3, CMD_RD, ADDR_W'(28'h300), '0, '0);
      step();
      bus.i_port_valid = '0;
      set_req(1, CMD_RD, ADDR_W'(28'h310), '0, '0);
      step();
      bus.i_port_valid = '0;
      set_req(0, CMD_RD, ADDR_W'(28'h320), '0, '0);
      step();
      bus.i_port_valid = '0;
      repeat (3) step();
      for (int i = 0; i < 3; i++) d[i] = {$urandom(), $urandom()};
      bus.i_mc_rd_data_valid = 1'b1;
      bus.i_mc_rd_data = d[0];
      step();
      check("s4_port3", 128'(bus.o_port_rd_valid), 128'(4'b1000));
      check("s4_data0", 128'(bus.o_port_rd_data), 128'(d[0]));
      bus.i_mc_rd_data = d[1];
      step();
      check("s4_port1", 128'(bus.o_port_rd_valid), 128'(4'b0010));
      check("s4_data1", 128'(bus.o_port_rd_data), 128'(d[1]));
      bus.i_mc_rd_data = d[2];
      step();
      check("s4_port0", 128'(bus.o_port_rd_valid), 128'(4'b0001));
      check("s4_data2", 128'(bus.o_port_rd_data), 128'(d[2]));
      bus.i_mc_rd_data_valid = 1'b0;
      step();
      check("s4_idle", 128'(bus.o_port_rd_valid), 128'(0));

      // Outstanding limit: nine reads, one write from port 3, no returns.
      do_reset();
      acc_log.delete();
      bus.i_mc_data_rdy = 1'b1;
      for (int c = 0; c < 3; c++) begin
         for (int p = 0; p < 3; p++) set_req(p, CMD_RD, ADDR_W'(p*16 + c), '0, '0);
         step();
      end
      bus.i_port_valid = '0;
      set_req(3, CMD_WR, ADDR_W'(28'h3F0), {$urandom(), $urandom()}, '0);
      step();
      bus.i_port_valid = '0;
      repeat (12) step();
      n_rd = 0;
      n_wr = 0;
      foreach (acc_log[i]) if (acc_log[i].cmd == CMD_RD) n_rd++; else n_wr++;
      check("s5_reads_issued", 128'(n_rd), 128'(RDO));
      check("s5_write_issued", 128'(n_wr), 128'(1));
      check("s5_stalled", 128'(bus.o_mc_valid), 128'(0));
      bus.i_mc_rd_data_valid = 1'b1;
      bus.i_mc_rd_data = {$urandom(), $urandom()};
      step();
      bus.i_mc_rd_data_valid = 1'b0;
      check("s5_first_ret", 128'(bus.o_port_rd_valid), 128'(4'b0001));
      check("s5_not_yet", 128'(bus.o_mc_valid), 128'(0));
      step();
      check("s5_ninth_valid", 128'(bus.o_mc_valid), 128'(1));
      check("s5_ninth_cmd", 128'(bus.o_mc_cmd), 128'(CMD_RD));
      check("s5_ninth_addr", 128'(bus.o_mc_addr), 128'(28'h22));
      drain(14);

      // Random traffic with random stalls and in-order returns.
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < NP; p++) begin
            if ($urandom_range(0, 1) == 1)
               set_req(p, logic'($urandom_range(0, 1)), ADDR_W'($urandom()),
                       {$urandom(), $urandom()}, DM_W'($urandom()));
            else
               bus.i_port_valid[p] = 1'b0;
         end
         bus.i_mc_data_rdy      = ($urandom_range(0, 3) != 0);
         bus.i_mc_rd_data_valid = (m_ord.size() > 0) && ($urandom_range(0, 2) == 0);
         bus.i_mc_rd_data       = {$urandom(), $urandom()};
         step();
      end
      drain(40);

      // Spurious return, then reset with loaded queues.
      bus.i_mc_rd_data_valid = 1'b1;
      bus.i_mc_rd_data = {$urandom(), $urandom()};
      step();
      bus.i_mc_rd_data_valid = 1'b0;
      check("s6_err", 128'(bus.o_err_sticky), 128'(1));
      check("s6_no_rd", 128'(bus.o_port_rd_valid), 128'(0));
      step();
      check("s6_err_sticks", 128'(bus.o_err_sticky), 128'(1));
      bus.i_mc_data_rdy = 1'b0;
      for (int c = 0; c < 3; c++) begin
         for (int p = 0; p < NP; p++)
            set_req(p, CMD_RD, ADDR_W'($urandom()), '0, '0);
         step();
      end
      do_reset();
      repeat (2) step();
      bus.i_mc_rd_data_valid = 1'b1;
      step();
      bus.i_mc_rd_data_valid = 1'b0;
      check("s6_post_rst_err", 128'(bus.o_err_sticky), 128'(1));
      check("s6_post_rst_rd", 128'(bus.o_port_rd_valid), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ddr3_cpu_port_arbiter.md
Name: ddr3_cpu_port_arbiter

Overview:
Multi-port front end for the DDR3 memory controller CPU interface. It accepts independent read and write requests from NUM_PORTS requesters over per-port valid/ready handshakes, buffers each port in its own queue, and arbitrates round-robin onto the controller's single command port. Read data returning in order from the controller is steered back to the port that issued the read. It sits between the CPU-side agents and the memory controller, and generalises the single-requester CPU interface to N channels.

Parameters:
NUM_PORTS, 4, number of requester ports (2..8)
ADDR_W, ADDR_MCTRL, controller address width
DATA_W, 8*DQ_BITS, burst data width
DM_W, BURST_L, data-mask width (one bit per beat)
REQ_DEPTH, 4, per-port request FIFO depth (power of 2, at least 2)
RD_OUTSTANDING, 8, maximum reads in flight (order FIFO depth, power of 2)

Ports:
i_cpu_ck  in  1  clock
i_cpu_rst_n  in  1  asynchronous active-low reset
i_port_valid  in  NUM_PORTS  per-port request valid
o_port_ready  out  NUM_PORTS  per-port queue not full
i_port_cmd  in  NUM_PORTS  per-port command, CMD_RD=0, CMD_WR=1
i_port_addr  in  NUM_PORTS*ADDR_W  per-port address, port p at [p*ADDR_W +: ADDR_W]
i_port_wr_data  in  NUM_PORTS*DATA_W  per-port write data
i_port_dm  in  NUM_PORTS*DM_W  per-port data mask
o_port_rd_data  out  DATA_W  read data, broadcast to all ports
o_port_rd_valid  out  NUM_PORTS  one-hot, marks the port that owns o_port_rd_data
o_mc_valid  out  1  command valid to controller
o_mc_cmd  out  1  command to controller
o_mc_addr  out  ADDR_W  address to controller
o_mc_wr_data  out  DATA_W  write data to controller
o_mc_dm  out  DM_W  data mask to controller
i_mc_data_rdy  in  1  controller can accept a command
i_mc_rd_data  in  DATA_W  controller read data
i_mc_rd_data_valid  in  1  controller read data valid
o_err_sticky  out  1  read data arrived with no read outstanding

Behaviour:
- Reset: all FIFOs empty. o_mc_valid, o_port_rd_valid and o_err_sticky are 0. o_mc_* and o_port_rd_data are 0. The round-robin pointer is at port 0. o_port_ready is 0 while reset is asserted.
- Port enqueue: a request enters the port's queue when i_port_valid[p] && o_port_ready[p] on a rising edge. o_port_ready[p] = !full[p]. The port is not ready when full, even if the queue is popped in the same cycle.
- Output register: o_mc_* is a registered skid stage. A request is accepted downstream when o_mc_valid && i_mc_data_rdy. While o_mc_valid=1 and i_mc_data_rdy=0, every o_mc_* signal holds stable.
- Grant: the stage loads when (!o_mc_valid || i_mc_data_rdy) and at least one port is eligible. A port is eligible when its queue is non-empty and, if its head is a read, the order FIFO is not full.
- Arbitration: round-robin. The search starts at the port after the last grantee. The winner's head is popped into the stage in the same cycle. Back-to-back acceptance gives 1 command per cycle.
- Latency: an enqueue into an empty queue with an idle stage appears on o_mc_valid 2 cycles later (FIFO write, then stage load).
- Reads: when a read is loaded into the stage, its port index is pushed into the order FIFO. Reads from different ports are never reordered relative to their grant order.
- Read return: on i_mc_rd_data_valid, pop the order FIFO. Register i_mc_rd_data onto o_port_rd_data and assert o_port_rd_valid[idx] for 1 cycle (1-cycle latency). Return ordering relies on the controller returning reads in order.
- A grant push and a return pop of the order FIFO in the same cycle are both honoured; the count is unchanged.
- Spurious return: i_mc_rd_data_valid while the order FIFO is empty. The data is dropped, o_port_rd_valid stays 0, and o_err_sticky is set; it clears only on reset.
- Writes do not use the order FIFO and produce no completion.
- Reset mid-operation clears all queued and in-flight state immediately. Read data returned after reset is flagged as spurious.

Decomposition:
- DDR3MemPkg gains:
  - CMD_RD and CMD_WR constants.
  - The typedef mc_req_t, a packed struct {cmd, addr, wr_data, dm} used as the FIFO payload.
  - The localparam PORT_IDX_W = $clog2(NUM_PORTS), with a minimum of 1.
- One sub-module, ddr3_sync_fifo, parametrised in width and depth with full/empty flags and async active-low reset.
  - Instantiated NUM_PORTS times for the request queues, plus once for the order FIFO.

Test Plan:
1. Single port: port 2 enqueues WR addr 0x100, data 0xA5A5..., i_mc_data_rdy=1. Expect o_mc_valid 2 cycles later with cmd=1, addr=0x100, data matching, for 1 cycle; no o_port_rd_valid.
2. Fairness: all 4 ports hold 3 requests each, rdy=1. Expect grant order 0,1,2,3,0,1,2,3,0,1,2,3 with no bubbles (12 consecutive valid cycles).
3. Backpressure: i_mc_data_rdy=0 for 10 cycles with port 0 streaming. Expect o_mc_* stable, port 0 ready drops after 4 enqueues (REQ_DEPTH) plus 1 in the stage, and no request is lost or duplicated after rdy=1.
4. Read steering: ports 3,1,0 each issue RD in that order; the controller returns D0,D1,D2. Expect o_port_rd_valid = 4'b1000, 4'b0010, 4'b0001 carrying D0, D1, D2, each 1 cycle after return.
5. Outstanding limit: 9 reads with no returns. Expect only 8 accepted downstream; the ninth is issued 1 cycle after the first return. A write from another port behind it is still granted meanwhile.
6. Spurious and reset: pulse i_mc_rd_data_valid with nothing outstanding, expect o_err_sticky=1 and no rd_valid. Then assert i_cpu_rst_n=0 with queues loaded, expect all outputs 0 and ready=0; after release, ready returns to all-ones.
